// File: rtl/inst_sequencer_pkg.sv
// inst_sequencer_pkg - shared constants, field positions and state encoding
// for the microcoded instruction sequencer.
package inst_sequencer_pkg;

    // Sequencer opcodes held in the top nibble of each program word
    localparam logic [3:0] SEQ_NOP  = 4'd0;
    localparam logic [3:0] SEQ_RUN  = 4'd1;
    localparam logic [3:0] SEQ_JMP  = 4'd2;
    localparam logic [3:0] SEQ_LDC  = 4'd3;
    localparam logic [3:0] SEQ_DJNZ = 4'd4;
    localparam logic [3:0] SEQ_WAIT = 4'd5;
    localparam logic [3:0] SEQ_HLT  = 4'd6;

    // Program word field positions
    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 12;
    localparam int PAYLOAD_MSB = 11;
    localparam int PAYLOAD_LSB = 0;
    localparam int COUNT_MSB   = 7;
    localparam int COUNT_LSB   = 0;

    // Sequencer states; ST_STALL is only reachable in single-step builds
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WAIT,
        ST_HALT,
        ST_STALL
    } state_t;

endpackage

// File: rtl/inst_sequencer_counter.sv
// inst_sequencer_counter - 8-bit loadable down-counter with a zero flag.
// Used both as the loop counter and as the WAIT countdown.
module inst_sequencer_counter
    import inst_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       dec,
    output logic [7:0] count,
    output logic       zero
);

    // Load takes priority over decrement; decrement wraps 0 -> 255
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/inst_sequencer.sv
// inst_sequencer - microcoded sequencer feeding RegBankS4's inst/inst_en pair
// from an external synchronous program ROM, one word every two cycles.
// Build macro INST_SEQUENCER_STEP_EN adds a 'step' input and a STALL state
// entered after every RUN dispatch, released by step.
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
`ifdef INST_SEQUENCER_STEP_EN
    input  logic                  step,
`endif
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [15:0]           rom_data,
    output logic [11:0]           inst,
    output logic                  inst_en,
    output logic                  busy,
    output logic                  halted,
    output logic                  error
);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [11:0]           inst_next;
    logic                  inst_en_next;
    logic                  error_next;

    logic [3:0]            opcode;
    logic [11:0]           payload;
    logic [7:0]            count_byte;
    logic [ADDR_WIDTH-1:0] jump_target;

    logic                  cnt_load;
    logic                  cnt_dec;
    logic [7:0]            cnt_value;
    logic                  cnt_zero;
    logic                  wait_load;
    logic                  wait_dec;
    logic [7:0]            wait_value;
    logic                  wait_zero;

    assign opcode      = rom_data[OPCODE_MSB:OPCODE_LSB];
    assign payload     = rom_data[PAYLOAD_MSB:PAYLOAD_LSB];
    assign count_byte  = rom_data[COUNT_MSB:COUNT_LSB];
    assign jump_target = payload[ADDR_WIDTH-1:0];

    // The ROM address is the program counter itself, so the word for pc is
    // registered by the ROM at the end of FETCH and present during EXEC.
    assign rom_addr = pc;
    assign busy     = (state == ST_FETCH) || (state == ST_EXEC) ||
                      (state == ST_WAIT)  || (state == ST_STALL);
    assign halted   = (state == ST_HALT);

    inst_sequencer_counter loop_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (count_byte),
        .dec        (cnt_dec),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

    inst_sequencer_counter wait_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (wait_load),
        .load_value (count_byte),
        .dec        (wait_dec),
        .count      (wait_value),
        .zero       (wait_zero)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Program counter, dispatch outputs and sticky error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            pc      <= '0;
            inst    <= 12'h000;
            inst_en <= 1'b0;
            error   <= 1'b0;
        end else begin
            pc      <= pc_next;
            inst    <= inst_next;
            inst_en <= inst_en_next;
            error   <= error_next;
        end
    end

    // Next-state and decode: the word is acted on in EXEC, dispatch lands
    // one cycle later alongside the following FETCH.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        inst_next    = inst;
        inst_en_next = 1'b0;
        error_next   = error;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        wait_load    = 1'b0;
        wait_dec     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_FETCH;
                    pc_next    = '0;
                end
            end
            ST_HALT: begin
                if (run) begin
                    state_next = ST_FETCH;
                    pc_next    = '0;
                    error_next = 1'b0;
                end
            end
            ST_FETCH: begin
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                state_next = ST_FETCH;
                pc_next    = pc + ADDR_WIDTH'(1);
                case (opcode)
                    SEQ_NOP: begin
                    end
                    SEQ_RUN: begin
                        inst_next    = payload;
                        inst_en_next = 1'b1;
`ifdef INST_SEQUENCER_STEP_EN
                        state_next   = ST_STALL;
`endif
                    end
                    SEQ_JMP: begin
                        pc_next = jump_target;
                    end
                    SEQ_LDC: begin
                        cnt_load = 1'b1;
                    end
                    SEQ_DJNZ: begin
                        cnt_dec = 1'b1;
                        // New count is cnt-1; a zero count wraps to 255 and still jumps
                        if (cnt_zero || (cnt_value != 8'd1)) begin
                            pc_next = jump_target;
                        end
                    end
                    SEQ_WAIT: begin
                        if (count_byte != 8'd0) begin
                            wait_load  = 1'b1;
                            state_next = ST_WAIT;
                        end
                    end
                    SEQ_HLT: begin
                        state_next = ST_HALT;
                    end
                    default: begin
                        error_next = 1'b1;
                        state_next = ST_HALT;
                    end
                endcase
            end
            ST_WAIT: begin
                // Counter holds the cycles still to spend here, including this one
                if (wait_zero || (wait_value == 8'd1)) begin
                    state_next = ST_FETCH;
                end else begin
                    wait_dec = 1'b1;
                end
            end
            ST_STALL: begin
`ifdef INST_SEQUENCER_STEP_EN
                if (step) begin
                    state_next = ST_FETCH;
                end
`else
                state_next = ST_FETCH;
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer - directed and randomized programs run against an
// instruction-level reference model that predicts dispatch cycles, values,
// halt time and error flag.
module tb_inst_sequencer;

    logic        clock;
    logic        reset;
    logic        run;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [11:0] inst;
    logic        inst_en;
    logic        busy;
    logic        halted;
    logic        error;
`ifdef INST_SEQUENCER_STEP_EN
    logic        step;
`endif

    logic [15:0] rom [0:255];

    int          total;
    int          bad;

    // Reference model results
    int          exp_cyc[$];
    logic [11:0] exp_inst[$];
    int          exp_end;
    logic        exp_err;
    logic [7:0]  m_cnt;

    // Observed dispatches
    int          got_cyc[$];
    logic [11:0] got_inst[$];

    inst_sequencer #(.ADDR_WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
`ifdef INST_SEQUENCER_STEP_EN
        .step     (step),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .inst     (inst),
        .inst_en  (inst_en),
        .busy     (busy),
        .halted   (halted),
        .error    (error)
    );

    // 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous program ROM: data valid one cycle after the address
    always @(posedge clock) begin
        rom_data <= rom[rom_addr];
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_rom(input logic [15:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    // Instruction-level interpreter. Cycle 0 is the first FETCH; each word
    // takes 2 cycles (WAIT n takes 2+n), a RUN dispatch is seen 2 cycles
    // after its word starts, and halted is seen 2 cycles after HLT starts.
    task automatic run_model();
        logic [7:0]  pc;
        logic [7:0]  next;
        logic [15:0] w;
        logic [3:0]  op;
        logic [11:0] pay;
        int          t;
        exp_cyc.delete();
        exp_inst.delete();
        exp_end = -1;
        exp_err = 1'b0;
        pc = 8'd0;
        t  = 0;
        for (int steps = 0; steps < 2000; steps++) begin
            w   = rom[pc];
            op  = w[15:12];
            pay = w[11:0];
            if (op >= 4'd6) begin
                exp_end = t + 2;
                exp_err = (op != 4'd6);
                return;
            end
            if (op == 4'd1) begin
                exp_cyc.push_back(t + 2);
                exp_inst.push_back(pay);
            end
            t    = t + 2;
            next = pc + 8'd1;
            if (op == 4'd2) next = pay[7:0];
            if (op == 4'd3) m_cnt = pay[7:0];
            if (op == 4'd4) begin
                m_cnt = m_cnt - 8'd1;
                if (m_cnt != 8'd0) next = pay[7:0];
            end
            if (op == 4'd5) t = t + int'(pay[7:0]);
            pc = next;
        end
    endtask

    // Pulse run and let the sequencer execute until it halts
    task automatic apply_stimulus(output int end_k);
        got_cyc.delete();
        got_inst.delete();
        end_k = -1;
        @(negedge clock);
        run = 1'b1;
        @(posedge clock);
        #1 run = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (k == 0) begin
                check_output("start_busy", {31'd0, busy}, 32'd1);
                check_output("start_rom_addr", {24'd0, rom_addr}, 32'd0);
                check_output("start_error", {31'd0, error}, 32'd0);
                check_output("start_halted", {31'd0, halted}, 32'd0);
            end
            if (inst_en) begin
                got_cyc.push_back(k);
                got_inst.push_back(inst);
            end
            if (halted) begin
                end_k = k;
                break;
            end
        end
    endtask

    // Run the current ROM contents and compare against the model
    task automatic run_and_check(input string tag);
        int end_k;
        run_model();
        apply_stimulus(end_k);
        check_output({tag, "_halted"}, {31'd0, halted}, 32'd1);
        check_output({tag, "_halt_cycle"}, end_k, exp_end);
        check_output({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, "_dispatches"}, got_cyc.size(), exp_cyc.size());
        for (int i = 0; i < exp_cyc.size() && i < got_cyc.size(); i++) begin
            check_output({tag, "_disp_cycle"}, got_cyc[i], exp_cyc[i]);
            check_output({tag, "_disp_inst"}, {20'd0, got_inst[i]}, {20'd0, exp_inst[i]});
        end
        if (exp_inst.size() > 0) begin
            check_output({tag, "_inst_hold"}, {20'd0, inst}, {20'd0, exp_inst[exp_inst.size()-1]});
        end
    endtask

    // Directed scenarios, then randomized programs, then reset mid-WAIT
    initial begin
        logic [31:0] r;
        logic [31:0] r2;
        int          n;
        int          tgt;
        total = 0;
        bad   = 0;
        run   = 1'b0;
        reset = 1'b1;
        m_cnt = 8'd0;
`ifdef INST_SEQUENCER_STEP_EN
        step  = 1'b1;
`endif
        clear_rom(16'h6000);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_output("reset_rom_addr", {24'd0, rom_addr}, 32'd0);
        check_output("reset_inst", {20'd0, inst}, 32'd0);
        check_output("reset_inst_en", {31'd0, inst_en}, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_halted", {31'd0, halted}, 32'd0);
        check_output("reset_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        $display("[TB] reset released");

        // Two back-to-back RUNs then HLT
        clear_rom(16'h6000);
        rom[0] = 16'h11AE;
        rom[1] = 16'h1000;
        rom[2] = 16'h6000;
        run_and_check("basic");

        // Counted loop: LDC 3; RUN 0x2FF; DJNZ 1; HLT
        clear_rom(16'h6000);
        rom[0] = 16'h3003;
        rom[1] = 16'h12FF;
        rom[2] = 16'h4001;
        rom[3] = 16'h6000;
        run_and_check("loop");

        // WAIT 5 between two RUNs
        clear_rom(16'h6000);
        rom[0] = 16'h1111;
        rom[1] = 16'h5005;
        rom[2] = 16'h1222;
        rom[3] = 16'h6000;
        run_and_check("wait5");

        // WAIT 0 behaves as NOP
        rom[1] = 16'h5000;
        run_and_check("wait0");

        // Illegal opcode at address 2, then a clean restart clears error
        clear_rom(16'h6000);
        rom[0] = 16'h0000;
        rom[1] = 16'h0000;
        rom[2] = 16'hF000;
        run_and_check("illegal");
        clear_rom(16'h6000);
        rom[0] = 16'h10AA;
        run_and_check("restart");

        // Program counter wrap: preload cnt=2, then loop through 0xFE/0xFF back to 0
        clear_rom(16'h6000);
        rom[0] = 16'h3002;
        run_and_check("preload");
        clear_rom(16'h0000);
        rom[0]    = 16'h4003;
        rom[1]    = 16'h6000;
        rom[3]    = 16'h1033;
        rom[4]    = 16'h20FE;
        rom[8'hFE] = 16'h10FE;
        rom[8'hFF] = 16'h0000;
        run_and_check("wrap");

        // Random forward-only programs; the last one ends on an illegal opcode
        for (int p = 0; p < 6; p++) begin
            clear_rom(16'h6000);
            n = int'($urandom_range(4, 10));
            for (int i = 0; i < n; i++) begin
                r   = $urandom;
                r2  = $urandom;
                tgt = int'($urandom_range(i + 1, n));
                case ($urandom_range(0, 6))
                    0:       rom[i] = {4'h0, r[11:0]};
                    1, 2:    rom[i] = {4'h1, r[11:0]};
                    3:       rom[i] = {4'h5, r[11:8], 5'd0, r2[2:0]};
                    4:       rom[i] = {4'h3, r[11:0]};
                    5:       rom[i] = {4'h4, r[11:8], 8'(tgt)};
                    default: rom[i] = {4'h2, r[11:8], 8'(tgt)};
                endcase
            end
            r = $urandom;
            rom[n] = (p == 5) ? {4'h9, r[11:0]} : 16'h6000;
            run_and_check("random");
        end

        // Reset asserted mid-WAIT drops everything; run then restarts cleanly
        clear_rom(16'h6000);
        rom[0] = 16'h1321;
        rom[1] = 16'h5014;
        rom[2] = 16'h1123;
        @(negedge clock);
        run = 1'b1;
        @(posedge clock);
        #1 run = 1'b0;
        repeat (7) @(negedge clock);
        check_output("midwait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_output("midreset_rom_addr", {24'd0, rom_addr}, 32'd0);
        check_output("midreset_inst", {20'd0, inst}, 32'd0);
        check_output("midreset_inst_en", {31'd0, inst_en}, 32'd0);
        check_output("midreset_busy", {31'd0, busy}, 32'd0);
        check_output("midreset_halted", {31'd0, halted}, 32'd0);
        check_output("midreset_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        m_cnt = 8'd0;
        run_and_check("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
